dispense_ctrl: RTL and testbench

DISPENSE_CTRL -- requirements
Module: dispense_ctrl

---
 rtl/dispense_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dispense_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_ctrl.sv
// rtl/dispense_ctrl.sv - vending dispense FSM: motor release, then coin-by-coin change payout.
// Optional motor timeout with refund is enabled by defining MOTOR_TIMEOUT_EN.
module dispense_ctrl #(
  parameter logic [3:0] PRICE_A       = 4'd2,
  parameter logic [3:0] PRICE_B       = 4'd3,
  parameter logic [3:0] MOTOR_TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_a,
  input  logic       vend_b,
  input  logic [3:0] credit,
  input  logic       motor_done,
  input  logic       coin_ack,
  output logic       motor_a,
  output logic       motor_b,
  output logic       coin_eject,
  output logic [3:0] change_left,
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [1:0] {S_IDLE, S_MOTOR, S_CHANGE, S_DONE} state_t;

  state_t     state_q, state_d;
  logic       motor_a_q, motor_a_d;
  logic       motor_b_q, motor_b_d;
  logic       coin_eject_q, coin_eject_d;
  logic [3:0] change_q, change_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

`ifdef MOTOR_TIMEOUT_EN
  logic [3:0] tmo_q, tmo_d;
  logic [3:0] credit_q, credit_d;
  logic       fault_q, fault_d;
  logic       expired;

  assign expired = (tmo_q == MOTOR_TIMEOUT - 4'd1);
`else
  logic unused_timeout;

  assign unused_timeout = ^MOTOR_TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    motor_a_d    = motor_a_q;
    motor_b_d    = motor_b_q;
    coin_eject_d = coin_eject_q;
    change_d     = change_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef MOTOR_TIMEOUT_EN
    tmo_d        = 4'd0;
    credit_d     = credit_q;
    fault_d      = fault_q;
`endif

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        change_d = 4'd0;
        // B takes precedence when both requests are affordable
        if (vend_b && (credit >= PRICE_B)) begin
          change_d  = credit - PRICE_B;
          motor_b_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_MOTOR;
`ifdef MOTOR_TIMEOUT_EN
          credit_d  = credit;
`endif
        end else if (vend_a && (credit >= PRICE_A)) begin
          change_d  = credit - PRICE_A;
          motor_a_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_MOTOR;
`ifdef MOTOR_TIMEOUT_EN
          credit_d  = credit;
`endif
        end
      end

      S_MOTOR: begin
        if (motor_done) begin
          motor_a_d = 1'b0;
          motor_b_d = 1'b0;
          if (change_q != 4'd0) begin
            coin_eject_d = 1'b1;
            state_d      = S_CHANGE;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
`ifdef MOTOR_TIMEOUT_EN
        end else if (expired) begin
          // refund the whole credit instead of the computed change
          motor_a_d = 1'b0;
          motor_b_d = 1'b0;
          fault_d   = 1'b1;
          change_d  = credit_q;
          if (credit_q != 4'd0) begin
            coin_eject_d = 1'b1;
            state_d      = S_CHANGE;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          tmo_d = tmo_q + 4'd1;
`endif
        end
      end

      S_CHANGE: begin
        if (coin_ack) begin
          change_d = change_q - 4'd1;
          if (change_q == 4'd1) begin
            coin_eject_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_DONE;
          end
        end
      end

      S_DONE: begin
        busy_d   = 1'b0;
        change_d = 4'd0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d      = S_IDLE;
        motor_a_d    = 1'b0;
        motor_b_d    = 1'b0;
        coin_eject_d = 1'b0;
        change_d     = 4'd0;
        busy_d       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      motor_a_q    <= 1'b0;
      motor_b_q    <= 1'b0;
      coin_eject_q <= 1'b0;
      change_q     <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef MOTOR_TIMEOUT_EN
      tmo_q        <= 4'd0;
      credit_q     <= 4'd0;
      fault_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      motor_a_q    <= motor_a_d;
      motor_b_q    <= motor_b_d;
      coin_eject_q <= coin_eject_d;
      change_q     <= change_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef MOTOR_TIMEOUT_EN
      tmo_q        <= tmo_d;
      credit_q     <= credit_d;
      fault_q      <= fault_d;
`endif
    end
  end

  assign motor_a     = motor_a_q;
  assign motor_b     = motor_b_q;
  assign coin_eject  = coin_eject_q;
  assign change_left = change_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef MOTOR_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule

// File: tb/tb_dispense_ctrl.sv
// tb/tb_dispense_ctrl.sv - directed self-checking bench for dispense_ctrl.
module tb_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vend_a = 1'b0;
  logic       vend_b = 1'b0;
  logic [3:0] credit = 4'd0;
  logic       motor_done = 1'b0;
  logic       coin_ack = 1'b0;
  logic       motor_a, motor_b, coin_eject, busy, done, fault;
  logic [3:0] change_left;

  int n_checks = 0;
  int n_fail = 0;

  dispense_ctrl dut (
    .clk(clk), .reset(reset), .vend_a(vend_a), .vend_b(vend_b), .credit(credit),
    .motor_done(motor_done), .coin_ack(coin_ack), .motor_a(motor_a), .motor_b(motor_b),
    .coin_eject(coin_eject), .change_left(change_left), .busy(busy), .done(done),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {motor_a, motor_b, coin_eject, busy, done, fault, change_left};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL reset_outputs actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
    motor_done = 1'b1;
    coin_ack = 1'b1;
    cyc();
    motor_done = 1'b0;
    coin_ack = 1'b0;
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL idle_ignores_done_ack actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
  endtask

  task automatic test_vend_a_change();
    vend_a = 1'b1;
    credit = 4'd5;
    cyc();
    vend_a = 1'b0;
    credit = 4'd0;
    n_checks++;
    if ({motor_a, motor_b, busy} !== 3'b101) begin
      $display("FAIL a_start actual=%b required=%b", {motor_a, motor_b, busy}, 3'b101);
      n_fail++;
    end
    cyc();
    cyc();
    n_checks++;
    if (motor_a !== 1'b1) begin
      $display("FAIL a_motor_hold actual=%b required=1", motor_a);
      n_fail++;
    end
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    n_checks++;
    if ({motor_a, coin_eject, change_left} !== {1'b0, 1'b1, 4'd3}) begin
      $display("FAIL a_to_change actual=%b required=%b", {motor_a, coin_eject, change_left},
               {1'b0, 1'b1, 4'd3});
      n_fail++;
    end
    coin_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_checks++;
      if (change_left !== 4'(2 - k)) begin
        $display("FAIL a_coin_%0d actual=%0d required=%0d", k, change_left, 2 - k);
        n_fail++;
      end
    end
    coin_ack = 1'b0;
    n_checks++;
    if ({coin_eject, done, busy} !== 3'b011) begin
      $display("FAIL a_done_pulse actual=%b required=%b", {coin_eject, done, busy}, 3'b011);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({done, busy, change_left} !== 6'd0) begin
      $display("FAIL a_back_idle actual=%b required=%b", {done, busy, change_left}, 6'd0);
      n_fail++;
    end
  endtask

  task automatic test_both_same_cycle();
    vend_a = 1'b1;
    vend_b = 1'b1;
    credit = 4'd3;
    cyc();
    vend_a = 1'b0;
    vend_b = 1'b0;
    n_checks++;
    if ({motor_a, motor_b, change_left} !== {1'b0, 1'b1, 4'd0}) begin
      $display("FAIL both_b_wins actual=%b required=%b", {motor_a, motor_b, change_left},
               {1'b0, 1'b1, 4'd0});
      n_fail++;
    end
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    n_checks++;
    if ({motor_b, coin_eject, done} !== 3'b001) begin
      $display("FAIL both_skip_change actual=%b required=%b", {motor_b, coin_eject, done}, 3'b001);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      $display("FAIL both_idle actual=%b required=%b", {done, busy}, 2'b00);
      n_fail++;
    end
  endtask

  task automatic test_drops();
    vend_b = 1'b1;
    credit = 4'd2;
    cyc();
    vend_b = 1'b0;
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL drop_b_low_credit actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
    vend_a = 1'b1;
    credit = 4'd1;
    cyc();
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL drop_a_low_credit actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
    credit = 4'd2;
    cyc();
    vend_a = 1'b1;
    vend_b = 1'b1;
    credit = 4'd9;
    cyc();
    vend_a = 1'b0;
    vend_b = 1'b0;
    n_checks++;
    if ({motor_a, motor_b, busy, change_left} !== {3'b101, 4'd0}) begin
      $display("FAIL drop_in_motor actual=%b required=%b", {motor_a, motor_b, busy, change_left},
               {3'b101, 4'd0});
      n_fail++;
    end
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    cyc();
    cyc();
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL drop_not_queued actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
  endtask

  task automatic test_hold_and_reset();
    vend_b = 1'b1;
    credit = 4'd7;
    cyc();
    vend_b = 1'b0;
    coin_ack = 1'b1;
    cyc();
    coin_ack = 1'b0;
    n_checks++;
    if ({motor_b, coin_eject, change_left} !== {2'b10, 4'd4}) begin
      $display("FAIL ack_in_motor_ignored actual=%b required=%b", {motor_b, coin_eject, change_left},
               {2'b10, 4'd4});
      n_fail++;
    end
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      n_checks++;
      if ({coin_eject, change_left} !== {1'b1, 4'd4}) begin
        $display("FAIL hold_no_ack_%0d actual=%b required=%b", k, {coin_eject, change_left},
                 {1'b1, 4'd4});
        n_fail++;
      end
    end
    coin_ack = 1'b1;
    cyc();
    n_checks++;
    if (change_left !== 4'd3) begin
      $display("FAIL hold_one_ack actual=%0d required=3", change_left);
      n_fail++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    coin_ack = 1'b0;
    n_checks++;
    if (outs() !== 10'd0) begin
      $display("FAIL reset_mid_change actual=%b required=%b", outs(), 10'd0);
      n_fail++;
    end
  endtask

`ifdef MOTOR_TIMEOUT_EN
  task automatic test_timeout();
    vend_a = 1'b1;
    credit = 4'd4;
    cyc();
    vend_a = 1'b0;
    for (int k = 0; k < 14; k++) cyc();
    n_checks++;
    if ({motor_a, fault} !== 2'b10) begin
      $display("FAIL tmo_before actual=%b required=%b", {motor_a, fault}, 2'b10);
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({motor_a, fault, coin_eject, change_left} !== {3'b011, 4'd4}) begin
      $display("FAIL tmo_expire actual=%b required=%b", {motor_a, fault, coin_eject, change_left},
               {3'b011, 4'd4});
      n_fail++;
    end
    coin_ack = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    coin_ack = 1'b0;
    n_checks++;
    if ({done, fault, change_left} !== {2'b11, 4'd0}) begin
      $display("FAIL tmo_refund_done actual=%b required=%b", {done, fault, change_left},
               {2'b11, 4'd0});
      n_fail++;
    end
    cyc();
    n_checks++;
    if ({busy, fault} !== 2'b01) begin
      $display("FAIL tmo_sticky actual=%b required=%b", {busy, fault}, 2'b01);
      n_fail++;
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++;
    if (fault !== 1'b0) begin
      $display("FAIL tmo_reset_clears actual=%b required=0", fault);
      n_fail++;
    end
  endtask
`else
  task automatic test_no_timeout();
    vend_a = 1'b1;
    credit = 4'd4;
    cyc();
    vend_a = 1'b0;
    for (int k = 0; k < 30; k++) cyc();
    n_checks++;
    if ({motor_a, fault, busy, change_left} !== {3'b101, 4'd2}) begin
      $display("FAIL no_tmo_wait actual=%b required=%b", {motor_a, fault, busy, change_left},
               {3'b101, 4'd2});
      n_fail++;
    end
    motor_done = 1'b1;
    cyc();
    motor_done = 1'b0;
    coin_ack = 1'b1;
    cyc();
    cyc();
    coin_ack = 1'b0;
    n_checks++;
    if ({done, fault, change_left} !== {2'b10, 4'd0}) begin
      $display("FAIL no_tmo_done actual=%b required=%b", {done, fault, change_left},
               {2'b10, 4'd0});
      n_fail++;
    end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_vend_a_change();
    test_both_same_cycle();
    test_drops();
    test_hold_and_reset();
`ifdef MOTOR_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
